// File: rtl/mmu_feeder.sv
// Weight-load then diagonally skewed activation sequencer for an NxN weight-stationary MMU.
// Weight row shows 1 cycle after accept and vector lane i 1+i cycles after; readies are registered phase flags, and the MMU side never stalls.
module mmu_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            reuse_wt,
  input  logic [N*DW-1:0] s_wt_data,
  input  logic            s_wt_valid,
  output logic            s_wt_ready,
  input  logic [N*DW-1:0] s_act_data,
  input  logic            s_act_valid,
  input  logic            s_act_last,
  output logic            s_act_ready,
  output logic            control,
  output logic [N*DW-1:0] wt_arr,
  output logic [N*DW-1:0] data_arr,
  output logic [N-1:0]    lane_valid,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   vec_count
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD_WT, STREAM, FLUSH, DONE} state_t;

  state_t        state;
  logic [RW-1:0] row_cnt;
  logic [RW-1:0] flush_cnt;
  logic          wt_acc;
  logic          act_acc;

  assign wt_acc  = s_wt_valid & s_wt_ready;
  assign act_acc = s_act_valid & s_act_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row_cnt     <= '0;
      flush_cnt   <= '0;
      s_wt_ready  <= 1'b0;
      s_act_ready <= 1'b0;
      control     <= 1'b0;
      wt_arr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      vec_count   <= '0;
    end else begin
      control <= 1'b0;
      wt_arr  <= '0;
      done    <= 1'b0;
      if (act_acc && vec_count != {CW{1'b1}})
        vec_count <= vec_count + CW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            vec_count <= '0;
            busy      <= 1'b1;
            if (reuse_wt) begin
              state       <= STREAM;
              s_act_ready <= 1'b1;
            end else begin
              state      <= LOAD_WT;
              s_wt_ready <= 1'b1;
              row_cnt    <= '0;
            end
          end
        end
        LOAD_WT: begin
          if (wt_acc) begin
            control <= 1'b1;
            wt_arr  <= s_wt_data;
            if (row_cnt == LAST_IDX) begin
              state       <= STREAM;
              s_wt_ready  <= 1'b0;
              s_act_ready <= 1'b1;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        STREAM: begin
          if (act_acc && s_act_last) begin
            state       <= FLUSH;
            s_act_ready <= 1'b0;
            flush_cnt   <= '0;
          end
        end
        FLUSH: begin
          // Hold until the last vector's top lane has left the skew.
          if (flush_cnt == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + RW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Non-accepting cycles push zero/invalid into every lane so bubbles keep their diagonal.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] lane_in;
    logic [DW-1:0] out_q;
    logic          out_v;

    assign lane_in               = act_acc ? s_act_data[i*DW +: DW] : '0;
    assign data_arr[i*DW +: DW]  = out_q;
    assign lane_valid[i]         = out_v;

    if (i == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (reset) begin
          out_q <= '0;
          out_v <= 1'b0;
        end else begin
          out_q <= lane_in;
          out_v <= act_acc;
        end
      end
    end else begin : g_delay
      logic [DW-1:0] dly [i];
      logic [i-1:0]  dly_v;

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < i; j++) dly[j] <= '0;
          dly_v <= '0;
          out_q <= '0;
          out_v <= 1'b0;
        end else begin
          dly[0]   <= lane_in;
          dly_v[0] <= act_acc;
          for (int j = 1; j < i; j++) begin
            dly[j]   <= dly[j-1];
            dly_v[j] <= dly_v[j-1];
          end
          out_q <= dly[i-1];
          out_v <= dly_v[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_mmu_feeder.sv
// Bench for mmu_feeder: job-level reference model checked every cycle, plus literal sequences from hand calculation.
module tb_mmu_feeder;
  localparam int N = 4, DW = 8, CW = 3, W = N * DW, DEPTH = 2048;

  logic          clk = 1'b0;
  logic          reset, start, reuse_wt;
  logic [W-1:0]  s_wt_data, s_act_data;
  logic          s_wt_valid, s_wt_ready, s_act_valid, s_act_last, s_act_ready;
  logic          control, busy, done;
  logic [W-1:0]  wt_arr, data_arr;
  logic [N-1:0]  lane_valid;
  logic [CW-1:0] vec_count;

  mmu_feeder #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .reuse_wt(reuse_wt),
    .s_wt_data(s_wt_data), .s_wt_valid(s_wt_valid), .s_wt_ready(s_wt_ready),
    .s_act_data(s_act_data), .s_act_valid(s_act_valid), .s_act_last(s_act_last),
    .s_act_ready(s_act_ready), .control(control), .wt_arr(wt_arr),
    .data_arr(data_arr), .lane_valid(lane_valid), .busy(busy), .done(done),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: per-edge record of what was accepted and the job-level status afterwards.
  logic         aacc [DEPTH];
  logic [W-1:0] adat [DEPTH];
  logic         wacc [DEPTH];
  logic [W-1:0] wdat [DEPTH];
  logic         xbusy [DEPTH], xdone [DEPTH], xwr [DEPTH], xar [DEPTH];
  int           xcnt [DEPTH];
  bit           in_job = 0, has_last = 0, m_wa, m_aa;
  int           rows = N, cnt = 0, last_e = -100, rst_e = -1, m_e;

  always @(posedge clk) begin
    m_e = cyc;
    m_wa = 0;
    m_aa = 0;
    if (reset) begin
      in_job = 0; has_last = 0; cnt = 0; rows = N; rst_e = m_e;
    end else begin
      m_wa = in_job && rows < N && s_wt_valid;
      m_aa = in_job && rows == N && !has_last && s_act_valid;
      if (m_wa) rows++;
      if (m_aa) begin
        if (cnt < (1 << CW) - 1) cnt++;
        if (s_act_last) begin has_last = 1; last_e = m_e; end
      end
      if (in_job && has_last && m_e == last_e + N + 1) in_job = 0;
      else if (!in_job && start) begin
        in_job = 1; rows = reuse_wt ? N : 0; cnt = 0; has_last = 0;
      end
    end
    if (m_e < DEPTH) begin
      aacc[m_e] = m_aa; adat[m_e] = s_act_data;
      wacc[m_e] = m_wa; wdat[m_e] = s_wt_data;
      xbusy[m_e] = in_job;
      xdone[m_e] = in_job && has_last && m_e == last_e + N;
      xwr[m_e]   = in_job && rows < N;
      xar[m_e]   = in_job && rows == N && !has_last;
      xcnt[m_e]  = cnt;
    end
    cyc = cyc + 1;
  end

  logic [31:0] obs_wt[$], obs_data[$], obs_lv[$];
  int          done_seen = 0, done_e = -1;
  logic [W-1:0] exp_data;
  logic [N-1:0] exp_lv;
  int           c_e, c_j;

  always @(negedge clk) begin
    c_e = cyc - 1;
    if (c_e >= 0 && c_e < DEPTH) begin
      exp_data = '0;
      exp_lv   = '0;
      for (int i = 0; i < N; i++) begin
        c_j = c_e - i;
        if (c_j > rst_e && c_j >= 0 && aacc[c_j]) begin
          exp_data[i*DW +: DW] = adat[c_j][i*DW +: DW];
          exp_lv[i] = 1'b1;
        end
      end
      chk("data_arr", data_arr, exp_data);
      chk("lane_valid", 32'(lane_valid), 32'(exp_lv));
      chk("control", 32'(control), 32'(wacc[c_e]));
      chk("wt_arr", wt_arr, wacc[c_e] ? wdat[c_e] : '0);
      chk("busy", 32'(busy), 32'(xbusy[c_e]));
      chk("done", 32'(done), 32'(xdone[c_e]));
      chk("s_wt_ready", 32'(s_wt_ready), 32'(xwr[c_e]));
      chk("s_act_ready", 32'(s_act_ready), 32'(xar[c_e]));
      chk("vec_count", 32'(vec_count), 32'(xcnt[c_e]));
      if (control) obs_wt.push_back(wt_arr);
      if (lane_valid != 0) begin
        obs_data.push_back(data_arr);
        obs_lv.push_back(32'(lane_valid));
      end
      if (done) begin done_seen++; done_e = c_e; end
    end
  end

  int last_drv = 0, first_drv = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_obs();
    obs_wt.delete(); obs_data.delete(); obs_lv.delete();
  endtask

  task automatic do_start(input bit reuse);
    start = 1; reuse_wt = reuse;
    step();
    start = 0; reuse_wt = 0;
  endtask

  task automatic load_rows();
    logic [W-1:0] r [4];
    r = '{32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403};
    for (int k = 0; k < 4; k++) begin
      s_wt_valid = 1; s_wt_data = r[k];
      step();
    end
    s_wt_valid = 0; s_wt_data = '0;
  endtask

  task automatic send_vec(input logic [W-1:0] d, input bit last);
    s_act_valid = 1; s_act_data = d; s_act_last = last;
    if (last) last_drv = cyc;
    step();
    s_act_valid = 0; s_act_data = '0; s_act_last = 0;
  endtask

  task automatic wait_done(input string nm);
    int ds;
    ds = done_seen;
    for (int k = 0; k < 30 && done_seen == ds; k++) step();
    chk(nm, 32'(done_seen != ds), 32'd1);
    step();
  endtask

  task automatic cmp_q(input string nm, input logic [31:0] got[$], input logic [31:0] want[$]);
    chk({nm, "_len"}, got.size(), want.size());
    for (int k = 0; k < want.size() && k < got.size(); k++) chk(nm, got[k], want[k]);
  endtask

  initial begin
    reset = 1; start = 0; reuse_wt = 0;
    s_wt_data = '0; s_wt_valid = 0; s_act_data = '0; s_act_valid = 0; s_act_last = 0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'({s_wt_ready, s_act_ready}), 0);
    chk("rst_data", data_arr, 0);
    reset = 0;
    step();

    // Weight load then four back-to-back vectors.
    clr_obs();
    do_start(0);
    load_rows();
    step();
    cmp_q("wt_seq", obs_wt, '{32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403});
    clr_obs();
    send_vec(32'h00010101, 0);
    send_vec(32'h02010202, 0);
    send_vec(32'h04030100, 0);
    send_vec(32'h05010200, 1);
    wait_done("done_timeout_t2");
    cmp_q("skew_seq", obs_data, '{32'h00000001, 32'h00000102, 32'h00010200, 32'h00010100,
                                  32'h02030200, 32'h04010000, 32'h05000000});
    chk("done_lat_t2", done_e - last_drv, 4);
    chk("vec_count_t2", 32'(vec_count), 4);
    chk("idle_busy_t2", 32'(busy), 0);

    // One-cycle bubble after the first vector.
    clr_obs();
    do_start(1);
    first_drv = cyc;
    send_vec(32'h00010101, 0);
    step();
    send_vec(32'h02010202, 0);
    send_vec(32'h04030100, 0);
    send_vec(32'h05010200, 1);
    wait_done("done_timeout_t3");
    cmp_q("bubble_lv", obs_lv, '{32'h1, 32'h2, 32'h5, 32'hb, 32'h7, 32'he, 32'hc, 32'h8});
    chk("done_from_first_t3", done_e - first_drv, 8);

    // Reused weights, single-vector job.
    clr_obs();
    do_start(1);
    send_vec(32'h04030201, 1);
    wait_done("done_timeout_t4");
    chk("no_wt_t4", obs_wt.size(), 0);
    cmp_q("single_seq", obs_data, '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000});
    chk("done_lat_t4", done_e - last_drv, 4);

    // Reset in the middle of streaming aborts without done.
    do_start(1);
    send_vec(32'h11223344, 0);
    send_vec(32'h55667788, 0);
    reset = 1;
    step();
    chk("abort_data", data_arr, 0);
    chk("abort_lv", 32'(lane_valid), 0);
    chk("abort_flags", 32'({busy, done, s_act_ready, control}), 0);
    chk("abort_cnt", 32'(vec_count), 0);
    reset = 0;
    begin
      int ds;
      ds = done_seen;
      repeat (6) step();
      chk("abort_no_done", done_seen, ds);
    end
    do_start(0);
    load_rows();
    send_vec(32'h0a0b0c0d, 1);
    wait_done("done_timeout_t5");
    chk("vec_count_t5", 32'(vec_count), 1);

    // Ignored inputs: activations in IDLE, start and weights during STREAM.
    clr_obs();
    s_act_valid = 1; s_act_data = 32'hffffffff;
    repeat (2) step();
    s_act_valid = 0; s_act_data = '0;
    chk("idle_act_ignored", 32'(vec_count), 1);
    do_start(1);
    start = 1; s_wt_valid = 1; s_wt_data = 32'hdeadbeef;
    send_vec(32'h01010101, 0);
    send_vec(32'h02020202, 0);
    send_vec(32'h03030303, 1);
    start = 0; s_wt_valid = 0; s_wt_data = '0;
    wait_done("done_timeout_t6");
    chk("no_wt_t6", obs_wt.size(), 0);
    chk("vec_count_t6", 32'(vec_count), 3);
    chk("done_lat_t6", done_e - last_drv, 4);

    // Counter saturation with a narrow vec_count.
    do_start(1);
    for (int k = 0; k < 9; k++) send_vec(32'(k + 1), k == 8);
    wait_done("done_timeout_t7");
    chk("vec_count_sat", 32'(vec_count), 7);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
